// File: rtl/pc_stack.sv
// pc_stack: fetch-stage program counter with a hardware call/return stack.
//
// Each cycle exactly one action is taken, highest priority first:
// reset, stall, ret, call, load, increment. Lower-priority requests in the
// same cycle are dropped, not queued.
//
// Parameters:
//   WIDTH      address width in bits (pc and k)
//   DEPTH      number of return-stack entries (>= 1)
//   RESET_ADDR pc value after reset
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   stall  hold pc, depth, stack and flags this cycle
//   load   jump to target
//   rel    target = pc + k (k signed) when set, else target = k
//   call   push pc+1 and jump to target
//   ret    pop top of stack into pc
//   k      jump address or signed offset
//   pc     current instruction address (registered)
//   depth  number of valid stack entries (registered)
//   full   depth == DEPTH
//   empty  depth == 0
//   ovf    sticky: call attempted while full
//   unf    sticky: ret attempted while empty
module pc_stack #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       load,
  input  logic                       rel,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           k,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int unsigned DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic [WIDTH-1:0] pc_inc_s;
  logic [WIDTH-1:0] target_s;
  logic [WIDTH-1:0] top_s;
  logic             full_s;
  logic             empty_s;

  // Depth decode and shared arithmetic; all additions wrap modulo 2^WIDTH,
  // and adding a WIDTH-bit k is the same as adding it sign-extended.
  always_comb begin
    full_s   = (depth_q == DW'(DEPTH));
    empty_s  = (depth_q == DW'(0));
    pc_inc_s = pc_q + WIDTH'(1);
    if (rel) begin
      target_s = pc_q + k;
    end else begin
      target_s = k;
    end
  end

  // Top-of-stack read: entry depth-1 (only meaningful when not empty).
  always_comb begin
    top_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i) == (depth_q - DW'(1))) begin
        top_s = stack_q[i];
      end else begin
        top_s = top_s;
      end
    end
  end

  // Next-state logic in priority order stall > ret > call > load > increment.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stack_d = stack_q;
    if (stall) begin
      pc_d = pc_q;
    end else if (ret) begin
      if (!empty_s) begin
        pc_d    = top_s;
        depth_d = depth_q - DW'(1);
      end else begin
        pc_d  = pc_inc_s;
        unf_d = 1'b1;
      end
    end else if (call) begin
      // The jump is taken even when the push must be dropped.
      pc_d = target_s;
      if (!full_s) begin
        depth_d = depth_q + DW'(1);
        for (int i = 0; i < DEPTH; i++) begin
          if (DW'(i) == depth_q) begin
            stack_d[i] = pc_inc_s;
          end else begin
            stack_d[i] = stack_q[i];
          end
        end
      end else begin
        ovf_d = 1'b1;
      end
    end else if (load) begin
      pc_d = target_s;
    end else begin
      pc_d = pc_inc_s;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= WIDTH'(RESET_ADDR);
      depth_q <= DW'(0);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage; contents are don't-care after reset since depth is 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      stack_q[i] <= stack_d[i];
    end
  end

  assign pc    = pc_q;
  assign depth = depth_q;
  assign full  = full_s;
  assign empty = empty_s;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed steps from the test plan followed
// by random commands, checked against a queue-based reference model.
module tb_pc_stack;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int RA = 16;
  localparam int DW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset, stall, load, rel, call, ret;
  logic [W-1:0]  k;
  logic [W-1:0]  pc;
  logic [DW-1:0] depth;
  logic          full, empty, ovf, unf;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stack[$];
  logic         m_ovf, m_unf;

  always #5 clk = ~clk;

  pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_ADDR(RA)) dut (
    .clk(clk), .reset(reset), .stall(stall), .load(load), .rel(rel),
    .call(call), .ret(ret), .k(k), .pc(pc), .depth(depth), .full(full),
    .empty(empty), .ovf(ovf), .unf(unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then check every output.
  task automatic step(input logic r, input logic s, input logic ld, input logic rl,
                      input logic c, input logic rt, input logic [W-1:0] kk);
    logic [W-1:0] tgt;
    reset = r; stall = s; load = ld; rel = rl; call = c; ret = rt; k = kk;
    tgt = rl ? m_pc + kk : kk;
    if (r) begin
      m_pc = W'(RA); m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (s) begin
      m_pc = m_pc;
    end else if (rt) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin m_pc = m_pc + 8'd1; m_unf = 1'b1; end
    end else if (c) begin
      if (m_stack.size() < D) m_stack.push_back(m_pc + 8'd1);
      else m_ovf = 1'b1;
      m_pc = tgt;
    end else if (ld) begin
      m_pc = tgt;
    end else begin
      m_pc = m_pc + 8'd1;
    end
    @(posedge clk);
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("depth", 32'(depth), 32'(m_stack.size()));
    chk("full", 32'(full), 32'(m_stack.size() == D));
    chk("empty", 32'(empty), 32'(m_stack.size() == 0));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("unf", 32'(unf), 32'(m_unf));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask
  task automatic do_load(input logic rl, input logic [W-1:0] kk);
    step(1'b0, 1'b0, 1'b1, rl, 1'b0, 1'b0, kk);
  endtask
  task automatic do_call(input logic [W-1:0] kk);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, kk);
  endtask
  task automatic do_ret();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset, then idle counting
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_pc", 32'(pc), 32'h10);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    idle(); idle(); idle();
    chk("idle_pc", 32'(pc), 32'h13);

    // Wraparound
    do_load(1'b0, 8'hFE);
    idle(); chk("wrap_ff", 32'(pc), 32'hFF);
    idle(); chk("wrap_00", 32'(pc), 32'h00);
    idle(); chk("wrap_01", 32'(pc), 32'h01);

    // Relative and absolute loads
    do_load(1'b0, 8'h05);
    do_load(1'b1, 8'hFD); chk("load_rel", 32'(pc), 32'h02);
    do_load(1'b0, 8'h80); chk("load_abs", 32'(pc), 32'h80);

    // Simple call / return
    do_load(1'b0, 8'h20);
    do_call(8'h40); chk("call_pc", 32'(pc), 32'h40); chk("call_depth", 32'(depth), 32'd1);
    idle(); idle(); chk("after_call_pc", 32'(pc), 32'h42);
    do_ret(); chk("ret_pc", 32'(pc), 32'h21); chk("ret_depth", 32'(depth), 32'd0);

    // Overflow: five calls with DEPTH=4
    do_call(8'h30); do_call(8'h40); do_call(8'h50); do_call(8'h60);
    chk("ovf_pre", 32'(ovf), 32'd0);
    do_call(8'h70);
    chk("ovf_pc", 32'(pc), 32'h70); chk("ovf_depth", 32'(depth), 32'd4);
    chk("ovf_full", 32'(full), 32'd1); chk("ovf_flag", 32'(ovf), 32'd1);
    do_ret(); chk("lifo0", 32'(pc), 32'h51);
    do_ret(); chk("lifo1", 32'(pc), 32'h41);
    do_ret(); chk("lifo2", 32'(pc), 32'h31);
    do_ret(); chk("lifo3", 32'(pc), 32'h22);
    do_ret(); chk("unf_pc", 32'(pc), 32'h23); chk("unf_flag", 32'(unf), 32'd1);

    // Priority: ret beats call and load
    do_call(8'h90);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
    chk("prio_pc", 32'(pc), 32'h24); chk("prio_depth", 32'(depth), 32'd0);
    // Stall with call holds everything; release lets the call through
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA0);
    chk("stall_pc", 32'(pc), 32'h24); chk("stall_depth", 32'(depth), 32'd0);
    do_call(8'hA0);
    chk("unstall_pc", 32'(pc), 32'hA0); chk("unstall_depth", 32'(depth), 32'd1);

    // Reset overrides a call at depth 2
    do_call(8'hB0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC0);
    chk("rstcall_pc", 32'(pc), 32'h10); chk("rstcall_depth", 32'(depth), 32'd0);
    chk("rstcall_ovf", 32'(ovf), 32'd0); chk("rstcall_unf", 32'(unf), 32'd0);

    // Random commands against the model
    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           8'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter for the processor fetch stage, successor to the plain load/increment PC. Adds absolute or PC-relative jumps, a hardware call/return stack of configurable depth, a fetch stall, and sticky stack-error flags. It feeds the instruction-memory address every cycle and takes jump, call and return commands from the decode/control unit.

## Interface
- WIDTH, 8, address width in bits; pc and k are WIDTH wide.
- DEPTH, 4, return-stack entries (≥1).
- RESET_ADDR, 0, pc value after reset.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all state this cycle (reset still wins).
- load  in  1  jump request.
- rel  in  1  with load or call: target = pc + k (two's complement); else target = k.
- call  in  1  push pc+1, jump to target.
- ret  in  1  pop top of stack into pc.
- k  in  WIDTH  jump address or signed offset.
- pc  out  WIDTH  current instruction address (registered).
- depth  out  $clog2(DEPTH+1)  number of valid stack entries.
- full  out  1  depth == DEPTH (combinational from depth).
- empty  out  1  depth == 0 (combinational from depth).
- ovf  out  1  sticky: call attempted while full.
- unf  out  1  sticky: ret attempted while empty.

## Operation
- One clock; reset is synchronous and active-high.
- Reset values: pc = RESET_ADDR, depth = 0, ovf = 0, unf = 0; stack contents don't-care.
- Per-cycle priority, highest first: reset, stall, ret, call, load, increment. Exactly one action per cycle; lower-priority requests in the same cycle are ignored (not queued).
- stall: pc, depth, stack, flags unchanged.
- ret, not empty: pc <= stack[depth-1]; depth <= depth-1.
- ret, empty: pc <= pc+1; depth unchanged; unf <= 1.
- call, not full: stack[depth] <= pc+1; depth <= depth+1; pc <= target.
- call, full: pc <= target (jump still taken); push dropped; depth and stack unchanged; ovf <= 1.
- load: pc <= target; stack untouched.
- Otherwise: pc <= pc+1.
- Arithmetic: pc+1 and pc+k are modulo 2^WIDTH. k is sign-extended only in rel mode. Pushed return address pc+1 also wraps: pc = all-ones pushes 0.
- rel is ignored when neither load nor call wins.
- ovf/unf clear only on reset.

## Timing
- All state updates on the rising edge of clk. pc, depth, ovf and unf are registers; full and empty decode depth only.
- Latency: a command sampled at edge N is visible on pc after edge N; pc changes once per unstalled cycle.
- No handshake. Commands are level-sampled each edge; a request held across a stall takes effect on the first unstalled edge.
- Reset asserted mid-call or mid-ret overrides it: the next cycle shows reset values.
- Back-to-back call/ret across consecutive cycles is legal. A ret in the cycle after a call returns the just-pushed address.

## Test plan
- Reset with RESET_ADDR=0x10, then 3 idle cycles -> pc 0x10, 0x11, 0x12, 0x13; depth 0, empty 1.
- pc=0xFE, 3 idle cycles -> 0xFF, 0x00, 0x01. At pc=0x05, load rel k=0xFD -> pc 0x02. load abs k=0x80 -> pc 0x80.
- At pc=0x20, call k=0x40; 2 idle cycles; ret -> pc 0x40, 0x41, 0x42, then 0x21; depth 1 then 0.
- DEPTH=4, 5 consecutive calls -> depth saturates at 4, full 1, ovf 1 after the 5th, pc = 5th target. Then 4 rets return the first four return addresses in LIFO order. A 5th ret -> pc+1, unf 1.
- Same cycle: ret, call and load with a non-empty stack -> only the pop occurs. Same cycle: stall with call -> nothing changes. Release stall -> call executes.
- Reset asserted together with call while depth=2 -> pc RESET_ADDR, depth 0, ovf/unf 0 on the next cycle.
